// File: rtl/ysyx_23060184_axi_arbiter.sv
// Two-master AXI4 arbiter: IFU (read-only) and LSU (read/write) share one SoC master port.
// A grant covers one complete transaction; round-robin on ties; a watchdog frees stuck grants.
module ysyx_23060184_axi_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ifu_req,
    input  logic                      lsu_req,
    output logic                      ifu_grant,
    output logic                      lsu_grant,
    output logic                      timeout_err,
    input  logic [DATA_WIDTH-1:0]     ifu_araddr,
    input  logic                      ifu_arvalid,
    output logic                      ifu_arready,
    output logic [DATA_WIDTH-1:0]     ifu_rdata,
    output logic [1:0]                ifu_rresp,
    output logic                      ifu_rlast,
    output logic                      ifu_rvalid,
    input  logic                      ifu_rready,
    input  logic [DATA_WIDTH-1:0]     lsu_araddr,
    input  logic                      lsu_arvalid,
    output logic                      lsu_arready,
    output logic [DATA_WIDTH-1:0]     lsu_rdata,
    output logic [1:0]                lsu_rresp,
    output logic                      lsu_rlast,
    output logic                      lsu_rvalid,
    input  logic                      lsu_rready,
    input  logic [DATA_WIDTH-1:0]     lsu_awaddr,
    input  logic                      lsu_awvalid,
    output logic                      lsu_awready,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0]   lsu_wstrb,
    input  logic                      lsu_wlast,
    input  logic                      lsu_wvalid,
    output logic                      lsu_wready,
    output logic [1:0]                lsu_bresp,
    output logic                      lsu_bvalid,
    input  logic                      lsu_bready,
    output logic [DATA_WIDTH-1:0]     soc_araddr,
    output logic                      soc_arvalid,
    input  logic                      soc_arready,
    input  logic [DATA_WIDTH-1:0]     soc_rdata,
    input  logic [1:0]                soc_rresp,
    input  logic                      soc_rlast,
    input  logic                      soc_rvalid,
    output logic                      soc_rready,
    output logic [DATA_WIDTH-1:0]     soc_awaddr,
    output logic                      soc_awvalid,
    input  logic                      soc_awready,
    output logic [DATA_WIDTH-1:0]     soc_wdata,
    output logic [DATA_WIDTH/8-1:0]   soc_wstrb,
    output logic                      soc_wlast,
    output logic                      soc_wvalid,
    input  logic                      soc_wready,
    input  logic [1:0]                soc_bresp,
    input  logic                      soc_bvalid,
    output logic                      soc_bready
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OWN_IFU = 2'd1;
    localparam logic [1:0] OWN_LSU = 2'd2;
    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;   // 0: IFU served last, 1: LSU served last
    logic [9:0] cnt_q, cnt_d;
    logic       owned, done, expired;

    assign ifu_grant   = (state_q == OWN_IFU);
    assign lsu_grant   = (state_q == OWN_LSU);
    assign owned       = ifu_grant | lsu_grant;
    assign done        = owned & ((soc_rvalid & soc_rready & soc_rlast) | (soc_bvalid & soc_bready));
    // Completion wins over a coincident watchdog expiry.
    assign expired     = owned & ~done & (cnt_q == TIMEOUT_CNT);
    assign timeout_err = expired;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ifu_req && lsu_req) state_d = last_q ? OWN_IFU : OWN_LSU;
                else if (lsu_req)       state_d = OWN_LSU;
                else if (ifu_req)       state_d = OWN_IFU;
            end
            OWN_IFU, OWN_LSU: begin
                cnt_d = cnt_q + 10'd1;
                if (done || expired) begin
                    state_d = IDLE;
                    last_d  = lsu_grant;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        soc_araddr  = '0;
        soc_arvalid = 1'b0;
        soc_rready  = 1'b0;
        soc_awaddr  = '0;
        soc_awvalid = 1'b0;
        soc_wdata   = '0;
        soc_wstrb   = '0;
        soc_wlast   = 1'b0;
        soc_wvalid  = 1'b0;
        soc_bready  = 1'b0;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rlast   = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rlast   = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;
        if (ifu_grant) begin
            soc_araddr  = ifu_araddr;
            soc_arvalid = ifu_arvalid;
            soc_rready  = ifu_rready;
            ifu_arready = soc_arready;
            ifu_rdata   = soc_rdata;
            ifu_rresp   = soc_rresp;
            ifu_rlast   = soc_rlast;
            ifu_rvalid  = soc_rvalid;
        end else if (lsu_grant) begin
            soc_araddr  = lsu_araddr;
            soc_arvalid = lsu_arvalid;
            soc_rready  = lsu_rready;
            soc_awaddr  = lsu_awaddr;
            soc_awvalid = lsu_awvalid;
            soc_wdata   = lsu_wdata;
            soc_wstrb   = lsu_wstrb;
            soc_wlast   = lsu_wlast;
            soc_wvalid  = lsu_wvalid;
            soc_bready  = lsu_bready;
            lsu_arready = soc_arready;
            lsu_rdata   = soc_rdata;
            lsu_rresp   = soc_rresp;
            lsu_rlast   = soc_rlast;
            lsu_rvalid  = soc_rvalid;
            lsu_awready = soc_awready;
            lsu_wready  = soc_wready;
            lsu_bresp   = soc_bresp;
            lsu_bvalid  = soc_bvalid;
        end
    end

endmodule

// File: doc/ysyx_23060184_axi_arbiter.md
# ysyx_23060184_axi_arbiter

Two-master to one-slave AXI4 arbiter between the core's fetch unit (IFU, read-only) and the memory-access unit (LSU, read/write) and the single SoC AXI4 master port. It produces the per-master `grant` that the memory-access unit waits on, and steers all five AXI4 channels from the granted master to the SoC. Ownership is held for exactly one complete transaction, with round-robin tie-break and a watchdog that forcibly releases a stuck grant.

## Interface
Parameters:
- DATA_WIDTH, 32, address/data width
- TIMEOUT, 1023, max cycles a grant may be held before forced release (counter width 10)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ifu_req  in  1  IFU wants the bus; held until its transaction completes
- lsu_req  in  1  LSU wants the bus (the LSU's `Drequest`); same hold rule
- ifu_grant  out  1  IFU owns the bus
- lsu_grant  out  1  LSU owns the bus (drives the LSU's `grant`)
- timeout_err  out  1  one-cycle pulse when the watchdog releases a grant
- ifu_ar{addr,valid} in DATA_WIDTH/1; ifu_arready out 1  IFU read address
- ifu_r{data,resp,last,valid} out DATA_WIDTH/2/1/1; ifu_rready in 1  IFU read data
- lsu_ar{addr,valid} in DATA_WIDTH/1; lsu_arready out 1  LSU read address
- lsu_r{data,resp,last,valid} out DATA_WIDTH/2/1/1; lsu_rready in 1  LSU read data
- lsu_aw{addr,valid} in DATA_WIDTH/1; lsu_awready out 1  LSU write address
- lsu_w{data,strb,last,valid} in DATA_WIDTH/4/1/1; lsu_wready out 1  LSU write data
- lsu_b{resp,valid} out 2/1; lsu_bready in 1  LSU write response
- soc_ar{addr,valid} out; soc_arready in; soc_r{data,resp,last,valid} in; soc_rready out
- soc_aw{addr,valid} out; soc_awready in; soc_w{data,strb,last,valid} out; soc_wready in
- soc_b{resp,valid} in; soc_bready out

## Operation
- States: IDLE, OWN_IFU, OWN_LSU. Register `last` (0 = IFU served last, 1 = LSU); reset `last`=0.
- IDLE: only lsu_req -> OWN_LSU; only ifu_req -> OWN_IFU; both -> master not served last (after reset: LSU). Neither -> stay.
- OWN_x: grant_x=1; x's ar/aw/w valids and payloads forwarded to soc_*; soc ready/response signals forwarded to x; soc_rready/soc_bready from x.
- Non-owner and IDLE: all soc_*valid, soc_rready, soc_bready = 0; all non-owner *ready and *valid outputs = 0; payload outputs don't-care (drive 0).
- Completion: (soc_rvalid & soc_rready & soc_rlast) or (soc_bvalid & soc_bready) while owned -> IDLE next edge, `last` updated to the owner.
- IFU never writes: in OWN_IFU soc_awvalid, soc_wvalid, soc_bready = 0.
- Watchdog: 10-bit counter cleared on entry to OWN_x, incremented each owned cycle; reaching TIMEOUT without completion -> IDLE next edge, timeout_err=1 for that one cycle, `last` updated as for completion.

## Timing
- Reset (async, immediate): state IDLE, grants 0, timeout_err 0, counter 0, all soc_* valid/ready outputs 0. Reset mid-transaction abandons it; no completion handshake required.
- Grant latency: req sampled in IDLE at edge N -> grant high from N+1 (registered).
- Release: completion handshake at edge M -> grant low from M+1; at least one IDLE cycle between consecutive grants (re-arbitration point).
- Channel routing is combinational from registered state; no added latency on any AXI channel.
- Req dropping while owned is ignored; only completion or timeout release.
- Completion and timeout in same cycle: treat as completion (timeout_err stays 0).

## Test plan
- Reset then lsu_req=1 only, LSU read araddr=0x8000_0000, soc returns rdata=0x1234_5678 rlast=1 -> lsu_grant high 1 cycle after req; lsu_rdata=0x1234_5678; grant low the cycle after r handshake.
- ifu_req and lsu_req rise together after reset -> LSU granted first; after its completion one IDLE cycle, then ifu_grant=1 (round robin).
- LSU write awaddr=0x1000, wdata=0xDEAD_BEEF, wstrb=0xF, soc bvalid=1 bresp=0 -> soc_aw/w mirror LSU values; release only after b handshake, not after w handshake.
- IFU owns bus, lsu_arvalid=1 -> soc_araddr stays IFU address; lsu_arready=0 throughout.
- Owner never gets rvalid for TIMEOUT=1023 cycles -> timeout_err pulses exactly once, grant drops next cycle, other pending master granted after one IDLE cycle.
- Assert rst during OWN_LSU with soc_arvalid=1 -> same cycle grants and soc_arvalid go 0; after release, arbitration restarts from IDLE with `last`=0.
